// File: rtl/dcache_responder.sv
// Direct-mapped, one-word-per-line, write-through data cache answering Dispatch load/store requests.
// Load misses stall Dispatch with busy while the line is refilled from backing memory.
//
// state  | meaning
// IDLE   | accepting requests; hits and stores answered next cycle
// REFILL | waiting for mem_rd_valid for the latched miss line
// REPLAY | refilled word on data/hit_indicator; requests not accepted
module dcache_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        operation_type,
    input  logic              store_instr_indicator,
    input  logic [ADDR_W-1:0] memory_address,
    input  logic [DATA_W-1:0] data_to_be_written_to_sram,
    input  logic [3:0]        bytes_select,
    output logic [DATA_W-1:0] data,
    output logic              hit_indicator,
    output logic              busy,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [3:0]        mem_wr_be
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL, REPLAY} state_t;

    state_t            state;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_arr  [LINES];
    logic [DATA_W-1:0] data_arr [LINES];
    logic [IDX_W-1:0]  miss_idx;
    logic [TAG_W-1:0]  miss_tag;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              is_load;
    logic              is_store;
    logic              line_hit;
    logic              unused_ok;

    assign req_idx   = memory_address[2 +: IDX_W];
    assign req_tag   = memory_address[ADDR_W-1 -: TAG_W];
    assign is_load   = (operation_type == 2'b01);
    assign is_store  = (operation_type == 2'b10);
    assign line_hit  = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign unused_ok = ^{store_instr_indicator, memory_address[1:0]};

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                      input logic [DATA_W-1:0] new_word,
                                                      input logic [3:0]        be);
        logic [DATA_W-1:0] m;
        m = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m[8*i +: 8] = new_word[8*i +: 8];
        end
        return m;
    endfunction

    // Array storage carries no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (state == REFILL && mem_rd_valid) begin
            data_arr[miss_idx] <= mem_rd_data;
            tag_arr[miss_idx]  <= miss_tag;
        end else if (state == IDLE && is_store && line_hit) begin
            data_arr[req_idx] <= merge_bytes(data_arr[req_idx], data_to_be_written_to_sram,
                                             bytes_select);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            valid         <= '0;
            miss_idx      <= '0;
            miss_tag      <= '0;
            data          <= '0;
            hit_indicator <= 1'b0;
            busy          <= 1'b0;
            mem_rd_req    <= 1'b0;
            mem_rd_addr   <= '0;
            mem_wr_en     <= 1'b0;
            mem_wr_addr   <= '0;
            mem_wr_data   <= '0;
            mem_wr_be     <= '0;
        end else begin
            hit_indicator <= 1'b0;
            mem_rd_req    <= 1'b0;
            mem_wr_en     <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_load) begin
                        if (line_hit) begin
                            data          <= data_arr[req_idx];
                            hit_indicator <= 1'b1;
                        end else begin
                            busy        <= 1'b1;
                            mem_rd_req  <= 1'b1;
                            mem_rd_addr <= {memory_address[ADDR_W-1:2], 2'b00};
                            miss_idx    <= req_idx;
                            miss_tag    <= req_tag;
                            state       <= REFILL;
                        end
                    end else if (is_store) begin
                        mem_wr_en     <= 1'b1;
                        mem_wr_addr   <= {memory_address[ADDR_W-1:2], 2'b00};
                        mem_wr_data   <= data_to_be_written_to_sram;
                        mem_wr_be     <= bytes_select;
                        hit_indicator <= 1'b1;
                    end
                end
                REFILL: begin
                    if (mem_rd_valid) begin
                        valid[miss_idx] <= 1'b1;
                        data            <= mem_rd_data;
                        hit_indicator   <= 1'b1;
                        busy            <= 1'b0;
                        state           <= REPLAY;
                    end
                end
                REPLAY: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: a cache model of cached word addresses schedules per-cycle
// expectations on a timeline; one negedge process compares the DUT against it.
module tb_dcache_responder;

    localparam int LINES = 16;
    localparam int T     = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  operation_type;
    logic        store_instr_indicator;
    logic [31:0] memory_address;
    logic [31:0] data_to_be_written_to_sram;
    logic [3:0]  bytes_select;
    logic [31:0] data;
    logic        hit_indicator;
    logic        busy;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_be;

    dcache_responder #(.ADDR_W(32), .DATA_W(32), .LINES(LINES)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .operation_type             (operation_type),
        .store_instr_indicator      (store_instr_indicator),
        .memory_address             (memory_address),
        .data_to_be_written_to_sram (data_to_be_written_to_sram),
        .bytes_select               (bytes_select),
        .data                       (data),
        .hit_indicator              (hit_indicator),
        .busy                       (busy),
        .mem_rd_req                 (mem_rd_req),
        .mem_rd_addr                (mem_rd_addr),
        .mem_rd_valid               (mem_rd_valid),
        .mem_rd_data                (mem_rd_data),
        .mem_wr_en                  (mem_wr_en),
        .mem_wr_addr                (mem_wr_addr),
        .mem_wr_data                (mem_wr_data),
        .mem_wr_be                  (mem_wr_be)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // expected-output timeline, indexed by cycle number
    bit          e_hit [T];
    bit          e_dchk[T];
    bit          e_busy[T];
    bit          e_rdreq[T];
    bit          e_wr  [T];
    bit          l_en  [T];
    logic [31:0] e_data[T];
    logic [31:0] e_rdaddr[T];
    logic [31:0] e_wraddr[T];
    logic [31:0] e_wrdata[T];
    logic [3:0]  e_be  [T];
    logic [31:0] l_data[T];

    // cache model: which word address each line holds, and its contents
    bit          m_valid[LINES];
    logic [29:0] m_word [LINES];
    logic [31:0] m_data [LINES];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < T) begin
            chk("hit_indicator", {31'd0, hit_indicator}, {31'd0, e_hit[cyc]});
            chk("busy", {31'd0, busy}, {31'd0, e_busy[cyc]});
            chk("mem_rd_req", {31'd0, mem_rd_req}, {31'd0, e_rdreq[cyc]});
            chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, e_wr[cyc]});
            if (e_rdreq[cyc]) chk("mem_rd_addr", mem_rd_addr, e_rdaddr[cyc]);
            if (e_wr[cyc]) begin
                chk("mem_wr_addr", mem_wr_addr, e_wraddr[cyc]);
                chk("mem_wr_data", mem_wr_data, e_wrdata[cyc]);
                chk("mem_wr_be", {28'd0, mem_wr_be}, {28'd0, e_be[cyc]});
            end
            if (e_hit[cyc] && e_dchk[cyc]) chk("data", data, e_data[cyc]);
            if (l_en[cyc]) chk("data_literal", data, l_data[cyc]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
        operation_type             = op;
        store_instr_indicator      = (op == 2'b10);
        memory_address             = addr;
        data_to_be_written_to_sram = wd;
        bytes_select               = be;
    endtask

    function automatic bit model_hit(input logic [31:0] addr);
        int i;
        i = int'(addr[5:2]);
        return m_valid[i] && (m_word[i] == addr[31:2]);
    endfunction

    // Load: n = cycles from mem_rd_req to mem_rd_valid on a miss; bop/baddr presented while stalled.
    task automatic do_load(input logic [31:0] addr, input int n, input logic [31:0] rdata,
                           input logic [1:0] bop, input logic [31:0] baddr,
                           input bit lit, input logic [31:0] lit_val);
        int k;
        int i;
        k = cyc;
        i = int'(addr[5:2]);
        present(2'b01, addr, 32'h0, 4'h0);
        if (model_hit(addr)) begin
            e_hit[k+1]  = 1'b1;
            e_dchk[k+1] = 1'b1;
            e_data[k+1] = m_data[i];
            if (lit) begin
                l_en[k+1]   = 1'b1;
                l_data[k+1] = lit_val;
            end
            tick();
            present(2'b00, 32'h0, 32'h0, 4'h0);
        end else begin
            e_rdreq[k+1]  = 1'b1;
            e_rdaddr[k+1] = {addr[31:2], 2'b00};
            for (int j = 1; j <= n + 1; j++) e_busy[k+j] = 1'b1;
            e_hit[k+2+n]  = 1'b1;
            e_dchk[k+2+n] = 1'b1;
            e_data[k+2+n] = rdata;
            if (lit) begin
                l_en[k+2+n]   = 1'b1;
                l_data[k+2+n] = lit_val;
            end
            tick();
            present(bop, baddr, 32'hFFFF_FFFF, 4'hF);
            repeat (n) tick();
            mem_rd_valid = 1'b1;
            mem_rd_data  = rdata;
            tick();
            mem_rd_valid = 1'b0;
            mem_rd_data  = $urandom;
            tick();
            present(2'b00, 32'h0, 32'h0, 4'h0);
            m_valid[i] = 1'b1;
            m_word[i]  = addr[31:2];
            m_data[i]  = rdata;
        end
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        int k;
        int i;
        k = cyc;
        i = int'(addr[5:2]);
        present(2'b10, addr, wd, be);
        e_wr[k+1]     = 1'b1;
        e_wraddr[k+1] = {addr[31:2], 2'b00};
        e_wrdata[k+1] = wd;
        e_be[k+1]     = be;
        e_hit[k+1]    = 1'b1;
        if (model_hit(addr)) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_data[i][8*b +: 8] = wd[8*b +: 8];
        end
        tick();
        present(2'b00, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        int k;
        rst_n        = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = 32'h0;
        present(2'b00, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;

        @(negedge clk);
        chk("reset_outputs", {data, hit_indicator, busy, mem_rd_req, mem_wr_en} == '0 ? 32'd0 : 32'd1, 32'd0);
        chk("reset_addrs", mem_rd_addr | mem_wr_addr | mem_wr_data | {28'd0, mem_wr_be}, 32'd0);
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // cold load, refill three cycles after the request, then a 1-cycle hit
        do_load(32'h40, 3, 32'hDEAD_BEEF, 2'b01, 32'h40, 1'b1, 32'hDEAD_BEEF);
        do_load(32'h40, 1, 32'h0, 2'b01, 32'h40, 1'b1, 32'hDEAD_BEEF);

        // store merge, then back-to-back load sees merged word
        do_store(32'h40, 32'h1122_3344, 4'b0101);
        do_load(32'h40, 1, 32'h0, 2'b01, 32'h40, 1'b1, 32'hDE22_BE44);

        // conflict miss on idx 0, fastest refill
        do_load(32'h80, 1, 32'hCAFE_F00D, 2'b01, 32'h80, 1'b0, 32'h0);
        do_load(32'h40, 2, 32'hDE22_BE44, 2'b01, 32'h40, 1'b0, 32'h0);

        // back-to-back hits and stores, store miss to another line, empty byte mask
        do_load(32'h40, 1, 32'h0, 2'b01, 32'h40, 1'b0, 32'h0);
        do_load(32'h40, 1, 32'h0, 2'b01, 32'h40, 1'b0, 32'h0);
        do_store(32'h44, 32'h5555_AAAA, 4'b1111);
        do_store(32'h40, 32'h0000_0000, 4'b0000);
        do_load(32'h40, 1, 32'h0, 2'b01, 32'h40, 1'b1, 32'hDE22_BE44);
        do_store(32'h40, 32'hA1B2_C3D4, 4'b1010);
        do_load(32'h40, 1, 32'h0, 2'b01, 32'h40, 1'b1, 32'hA122_C344);

        // reserved and none operations, indicator disagreeing
        present(2'b11, 32'h40, 32'h1234_5678, 4'hF);
        store_instr_indicator = 1'b1;
        repeat (3) tick();
        present(2'b00, 32'h40, 32'h1234_5678, 4'hF);
        store_instr_indicator = 1'b1;
        repeat (2) tick();
        present(2'b00, 32'h0, 32'h0, 4'h0);

        // stalled hit-load and stalled store are not accepted until after replay
        do_load(32'h84, 2, 32'h0BAD_CAFE, 2'b01, 32'h40, 1'b0, 32'h0);
        do_load(32'h40, 1, 32'h0, 2'b01, 32'h40, 1'b1, 32'hA122_C344);
        do_load(32'h88, 1, 32'h1357_9BDF, 2'b10, 32'h40, 1'b0, 32'h0);
        do_load(32'h40, 1, 32'h0, 2'b01, 32'h40, 1'b1, 32'hA122_C344);
        do_load(32'h84, 1, 32'h0, 2'b01, 32'h84, 1'b1, 32'h0BAD_CAFE);

        // reset in the middle of a refill, then a stray mem_rd_valid
        k = cyc;
        present(2'b01, 32'h48, 32'h0, 4'h0);
        e_rdreq[k+1]  = 1'b1;
        e_rdaddr[k+1] = 32'h48;
        e_busy[k+1]   = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        present(2'b00, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", {data, hit_indicator, busy, mem_rd_req, mem_wr_en} == '0 ? 32'd0 : 32'd1, 32'd0);
        chk("midreset_addrs", mem_rd_addr | mem_wr_addr | mem_wr_data | {28'd0, mem_wr_be}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'hFFFF_0000;
        tick();
        mem_rd_valid = 1'b0;
        tick();

        // store miss does not allocate; reset invalidated previous lines
        do_store(32'h100, 32'hA5A5_A5A5, 4'hF);
        do_load(32'h100, 1, 32'h7777_7777, 2'b01, 32'h100, 1'b1, 32'h7777_7777);
        do_load(32'h48, 2, 32'h2468_ACE0, 2'b01, 32'h48, 1'b1, 32'h2468_ACE0);
        do_load(32'h84, 1, 32'h3333_4444, 2'b01, 32'h84, 1'b0, 32'h0);
        do_load(32'h40, 1, 32'hA122_C344, 2'b01, 32'h40, 1'b0, 32'h0);
        do_load(32'h48, 1, 32'h0, 2'b01, 32'h48, 1'b1, 32'h2468_ACE0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_responder.md
# dcache_responder

Responder end of the Dispatch↔Wakeup memory-request interface. It accepts load/store requests from Dispatch (`operation_type`, `memory_address`, `data_to_be_written_to_sram`, `bytes_select`, `store_instr_indicator`) and returns `data` and `hit_indicator`. Requests are serviced from a direct-mapped, one-word-per-line, write-through data array. Load misses are refilled from a backing-memory port, and Dispatch is stalled with `busy` until the refill completes.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width. Fixed at 32 so that `bytes_select` is 4 bits.
- `LINES`, 16: number of lines. Power of 2, ≥2.

Clocking: one clock; reset is asynchronous and active-low.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `operation_type`  in  2: 00 none, 01 load, 10 store, 11 reserved (treated as none).
- `store_instr_indicator`  in  1: informational only; `operation_type` is authoritative when the two disagree.
- `memory_address`  in  ADDR_W: byte address. Bits [1:0] are ignored.
- `data_to_be_written_to_sram`  in  DATA_W: store data.
- `bytes_select`  in  4: store byte enables; bit i covers byte i.
- `data`  out  DATA_W: load result.
- `hit_indicator`  out  1: one-cycle pulse meaning "response valid".
- `busy`  out  1: high while a refill is in progress. Dispatch must hold its request while this is high.
- `mem_rd_req`  out  1: one-cycle refill request pulse.
- `mem_rd_addr`  out  ADDR_W: word-aligned refill address.
- `mem_rd_valid`  in  1: refill data valid.
- `mem_rd_data`  in  DATA_W: refill data.
- `mem_wr_en`  out  1: write-through pulse.
- `mem_wr_addr`  out  ADDR_W: write-through address.
- `mem_wr_data`  out  DATA_W: write-through data.
- `mem_wr_be`  out  4: write-through byte enables.

## Operation
Address split:
- `idx` = `memory_address`[2 +: log2(LINES)].
- `tag` = remaining upper bits.
- Per line state: valid bit, tag, data word.

FSM has three states: IDLE, REFILL, REPLAY.

IDLE:
- A request is accepted on a rising edge when `operation_type` ∈ {01, 10}.
- Load hit (valid and tag match): next cycle `data` = line word and `hit_indicator` = 1.
- Load miss:
  - Next cycle `hit_indicator` = 0, `busy` = 1, and `mem_rd_req` pulses with `mem_rd_addr` = {`memory_address`[ADDR_W-1:2], 2'b00}.
  - The request's index and tag are latched.
  - The FSM goes to REFILL.
- Store (hit or miss), never stalls:
  - Next cycle `mem_wr_en` pulses with the address, data and byte enables, and `hit_indicator` = 1 (store acknowledged).
  - On a tag hit, only the enabled bytes of the line are updated.
  - On a miss, the line is not allocated.
- Store with `bytes_select` = 0000: acknowledged and `mem_wr_en` still pulses, but the line is unchanged.

REFILL:
- `busy` = 1. New requests are ignored.
- When `mem_rd_valid` is seen: write `mem_rd_data` into the latched index, set valid, write the tag, and go to REPLAY.
- No timeout.

REPLAY (one cycle):
- `data` = refilled word, `hit_indicator` = 1, `busy` = 0. Return to IDLE.
- A request presented during REPLAY is not accepted. It is accepted on the following edge in IDLE.

Other rules:
- `mem_rd_valid` while in IDLE or REPLAY is ignored.
- `data` holds its last value when `hit_indicator` = 0.
- The store hit/miss decision is made against the array contents before the edge.

## Timing
- Reset values: every output is 0, all valid bits are 0, and the FSM is in IDLE.
- Reset asserted mid-refill: state and valid bits clear immediately. A `mem_rd_valid` arriving after reset is ignored.
- Hit latency: 1 cycle from the request edge to `hit_indicator`.
- Miss latency: 1 cycle to `busy`, then N cycles of refill, then a 1-cycle replay. Response arrives at edge + (N+2), where N is the cycle count from `mem_rd_req` to `mem_rd_valid`, N ≥ 1.
- `mem_rd_valid` asserted one cycle after `mem_rd_req` (fastest case) must still work.
- Throughput: back-to-back hits and stores sustain one request per cycle.
- Load to the same word immediately after a store hit returns the merged data.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Cold load, then refill:
  - Stimulus: after reset, load at 0x0000_0040; respond to `mem_rd_req` with `mem_rd_valid`=1, `mem_rd_data`=0xDEADBEEF three cycles later.
  - Required: `busy`=1 throughout; `hit_indicator`=1 with `data`=0xDEADBEEF exactly one cycle after `mem_rd_valid`.
  - Follow-up: a second load to 0x40 hits with 1-cycle latency.
- Store merge:
  - Stimulus: line at 0x40 holds 0xDEADBEEF; store 0x11223344 with `bytes_select`=0101.
  - Required: `mem_wr_en` pulses with `mem_wr_be`=0101; a following load returns 0xDE22BE44.
- Conflict miss:
  - Stimulus: load 0x40, then load 0x80 (LINES=16, same idx 0).
  - Required: the second load misses and refills; a load back to 0x40 misses again.
- Store miss, no allocate:
  - Stimulus: store to 0x100 while idx 0 is invalid.
  - Required: `hit_indicator`=1 and `mem_wr_en`=1; a subsequent load to 0x100 misses.
- Reset mid-refill and stray valid:
  - Stimulus: deassert `rst_n` while in REFILL, then pulse `mem_rd_valid`.
  - Required: all outputs 0 and no `hit_indicator`; the next load to the same address misses.
- Stall and ops:
  - Stimulus: while `busy`=1, present a load.
  - Required: it is not accepted until after REPLAY.
  - Stimulus: `operation_type`=11.
  - Required: no response and no memory traffic.
